// File: rtl/fft_butterfly_scheduler.sv
// Radix-2 decimation-in-time FFT butterfly scheduler.
// Issues the N/2 butterflies of each stage to an external datapath.
// Tracks write-backs that are still outstanding, and holds each stage boundary
// until every write-back of the previous stage has returned.
module fft_butterfly_scheduler #(
    parameter int unsigned N_SAMPLES = 8,
    localparam int unsigned LOG = $clog2(N_SAMPLES),
    localparam int unsigned AW  = LOG,
    localparam int unsigned TW  = LOG - 1,
    localparam int unsigned SW  = $clog2(LOG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          recv_val,
    output logic          recv_rdy,
    output logic          issue_val,
    input  logic          issue_rdy,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [TW-1:0] tw_idx,
    output logic [SW-1:0] stage,
    input  logic          wb_val,
    output logic          send_val,
    input  logic          send_rdy,
    output logic          err
);

    localparam int unsigned KW = LOG - 1;
    localparam int unsigned OW = $clog2(N_SAMPLES / 2 + 1);
    localparam logic [KW-1:0] LAST_K     = KW'(N_SAMPLES / 2 - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG - 1);
    localparam logic [OW-1:0] OUT_MAX    = '1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [OW-1:0] out_q, out_d;
    logic          err_q, err_d;
    logic          issue_fire;

    logic [AW-1:0] k_ext, span, pos, grp, base;

    // State registers, cleared asynchronously so an aborted pass leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            stage_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs, outstanding-count bookkeeping and next-state selection.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        out_d   = out_q;
        err_d   = err_q;

        recv_rdy   = (state_q == StIdle);
        issue_val  = (state_q == StIssue) && (out_q != OUT_MAX);
        send_val   = (state_q == StDone);
        issue_fire = issue_val && issue_rdy;

        // A same-cycle issue and write-back cancel out.
        if (issue_fire && !wb_val) begin
            out_d = out_q + 1'b1;
        end else if (!issue_fire && wb_val) begin
            if (out_q != '0) begin
                out_d = out_q - 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (issue_fire) begin
            k_d = k_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (recv_val) begin
                    state_d = StIssue;
                    stage_d = '0;
                    k_d     = '0;
                    out_d   = '0;
                end
            end
            StIssue: begin
                if (issue_fire && (k_q == LAST_K)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Hazard barrier: the next stage reads what this stage wrote.
                if (out_d == '0) begin
                    if (stage_q < LAST_STAGE) begin
                        stage_d = stage_q + 1'b1;
                        k_d     = '0;
                        state_d = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (send_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Butterfly address and twiddle generation; zero outside the issue state.
    always_comb begin
        k_ext = AW'(k_q);
        span  = AW'(1) << stage_q;
        pos   = k_ext & (span - AW'(1));
        grp   = k_ext >> stage_q;
        base  = ((grp << stage_q) << 1) | pos;

        addr_a = '0;
        addr_b = '0;
        tw_idx = '0;
        if (state_q == StIssue) begin
            addr_a = base;
            addr_b = base + span;
            tw_idx = TW'(pos << (LAST_STAGE - stage_q));
        end
    end

    assign stage = stage_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Directed bench for the FFT butterfly scheduler with N_SAMPLES = 8.
module tb_fft_butterfly_scheduler;

    logic       clk;
    logic       reset;
    logic       recv_val;
    logic       recv_rdy;
    logic       issue_val;
    logic       issue_rdy;
    logic [2:0] addr_a;
    logic [2:0] addr_b;
    logic [1:0] tw_idx;
    logic [1:0] stage;
    logic       wb_val;
    logic       send_val;
    logic       send_rdy;
    logic       err;

    logic       wb_drv;
    int         wb_mode;  // 0: write-back echoes accepted issue, 1: 5-cycle delay, 2: manual

    int n_checks = 0;
    int n_fail   = 0;

    int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    int         idx;
    int         wb_cnt;
    int         prev_stage;
    int         prev_tuple;
    int         lat;
    bit         prev_stall;
    bit         send_seen;
    bit         rnd_rdy;
    bit         fire;
    logic [7:0] pipe;

    fft_butterfly_scheduler #(.N_SAMPLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .issue_val (issue_val),
        .issue_rdy (issue_rdy),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .tw_idx    (tw_idx),
        .stage     (stage),
        .wb_val    (wb_val),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .err       (err)
    );

    assign wb_val = (wb_mode == 0) ? (issue_val && issue_rdy) : wb_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tup(input int s, input int a, input int b, input int t);
        return s * 1000 + a * 100 + b * 10 + t;
    endfunction

    // One clock cycle: drive inputs at posedge+1, observe at posedge+2.
    task step();
        int now;
        if (rnd_rdy) issue_rdy = 1'($urandom_range(0, 1));
        if (wb_mode == 1) wb_drv = pipe[4];
        #1;
        now  = tup(int'(stage), int'(addr_a), int'(addr_b), int'(tw_idx));
        fire = issue_val && issue_rdy;
        if (int'(stage) > prev_stage) check("stage_step_wb", wb_cnt, 4 * int'(stage));
        prev_stage = int'(stage);
        if (prev_stall) check("stall_hold", now, prev_tuple);
        if (fire) begin
            if (idx < 12) check("issue_tuple", now, tup(idx / 4, exp_a[idx], exp_b[idx], exp_tw[idx]));
            check("raw_barrier", (wb_cnt >= 4 * int'(stage)), 1);
            idx++;
        end
        if (wb_val) wb_cnt++;
        prev_stall = issue_val && !issue_rdy;
        prev_tuple = now;
        pipe = {pipe[6:0], fire};
        if (send_val) send_seen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task start_pass();
        idx        = 0;
        wb_cnt     = 0;
        prev_stage = 0;
        prev_stall = 1'b0;
        send_seen  = 1'b0;
        pipe       = '0;
        wb_drv     = 1'b0;
        recv_val   = 1'b1;
        @(posedge clk);
        #1;
        recv_val = 1'b0;
    endtask

    task run_to_done(input int budget, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        while (!done && cycles < budget) begin
            step();
            cycles++;
            if (send_val) done = 1'b1;
        end
        check("pass_done", done, 1);
        check("issue_count", idx, 12);
    endtask

    task release_done();
        send_rdy = 1'b1;
        @(posedge clk);
        #1;
        send_rdy = 1'b0;
        check("done_to_idle", recv_rdy, 1);
    endtask

    initial begin
        reset     = 1'b0;
        recv_val  = 1'b0;
        issue_rdy = 1'b1;
        send_rdy  = 1'b0;
        wb_drv    = 1'b0;
        wb_mode   = 0;
        rnd_rdy   = 1'b0;
        pipe      = '0;

        // Reset values
        #12;
        check("rst_recv_rdy", recv_rdy, 1);
        check("rst_issue_val", issue_val, 0);
        check("rst_send_val", send_val, 0);
        check("rst_addr_a", addr_a, 0);
        check("rst_addr_b", addr_b, 0);
        check("rst_tw_idx", tw_idx, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate pass, write-back in the issue cycle: 3*4 + 3 cycles
        start_pass();
        run_to_done(200, lat);
        check("latency_full_rate", lat, 15);

        // DONE held: send_val sticks, recv_val ignored
        for (int i = 0; i < 10; i++) begin
            recv_val = 1'b1;
            @(posedge clk);
            #1;
            check("done_hold_send", send_val, 1);
            check("done_hold_rdy", recv_rdy, 0);
        end
        recv_val = 1'b0;
        release_done();
        check("idle_no_issue", issue_val, 0);
        check("idle_no_send", send_val, 0);

        // Random back-pressure on issue
        rnd_rdy = 1'b1;
        start_pass();
        run_to_done(400, lat);
        rnd_rdy   = 1'b0;
        issue_rdy = 1'b1;
        release_done();

        // Write-backs delayed by 5 cycles: each stage spans 4 issues + 5 drain cycles
        wb_mode = 1;
        start_pass();
        run_to_done(400, lat);
        check("latency_delayed_wb", lat, 27);
        check("err_clear", err, 0);
        release_done();

        // Spurious write-back in IDLE
        wb_mode = 2;
        wb_drv  = 1'b1;
        @(posedge clk);
        #1;
        wb_drv = 1'b0;
        check("err_set", err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", err, 1);
        wb_mode = 0;
        start_pass();
        run_to_done(200, lat);
        check("latency_after_err", lat, 15);
        check("err_sticky_pass", err, 1);
        release_done();

        // Reset in the middle of stage 1
        start_pass();
        for (int i = 0; i < 50; i++) begin
            if (stage == 2'd1 && idx >= 6) break;
            step();
        end
        check("abort_reached_stage1", stage, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_recv_rdy", recv_rdy, 1);
        check("abort_issue_val", issue_val, 0);
        check("abort_send_val", send_val, 0);
        check("abort_addr_a", addr_a, 0);
        check("abort_addr_b", addr_b, 0);
        check("abort_tw_idx", tw_idx, 0);
        check("abort_stage", stage, 0);
        check("abort_err", err, 0);
        check("abort_no_send", send_seen, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_pass();
        run_to_done(200, lat);
        check("latency_after_abort", lat, 15);
        release_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
